qc_ldpc_enc_stream: RTL and testbench
=====================================

# qc_ldpc_enc_stream

Block-serial, runtime-configurable QC-LDPC parity encoder. Accepts one Z-bit info block per handshake, accumulates every parity row in parallel as the XOR of cyclically rotated info blocks, then streams the parity blocks out. Circulant size (27/54/81), info-block count and parity-block count are selected per frame. The shift table is loaded at runtime through a config port. Sits between the info-block framer and the codeword assembler in the encoder datapath.

## Interface
- ZMAX, 81, widest circulant; data port width
- KB_MAX, 20, max info blocks per frame
- MB_MAX, 12, max parity blocks per frame
- SW, $clog2(ZMAX), shift field width (7 at default)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  shift-table write strobe
- cfg_row  in  $clog2(MB_MAX)  parity row r
- cfg_col  in  $clog2(KB_MAX)  info column c
- cfg_shift  in  SW  rotation amount
- cfg_null  in  1  1 marks entry (r,c) as a zero block
- frm_z_sel  in  2  0→z=27, 1→z=54, 2→z=81, 3 illegal
- frm_kb  in  5  info blocks this frame
- frm_mb  in  4  parity blocks this frame
- in_valid / in_ready  in / out  1  info-beat handshake
- in_data  in  ZMAX  info block; bits ≥ z ignored
- par_valid / par_ready  out / in  1  parity-beat handshake
- par_data  out  ZMAX  parity block; bits ≥ z driven 0
- par_idx  out  $clog2(MB_MAX)  parity row of current beat
- par_last  out  1  high with final parity beat
- frm_err  out  1  one-cycle pulse on an illegal-parameter attempt

## Operation
- Table: MB_MAX×KB_MAX entries of {null, shift}. The entry is written on cfg_we only in IDLE; writes are ignored in other states. Reset sets every entry to null.
- Rotation: rot(v,s) maps input bit j to output bit (j+s) mod z for j<z. Output bits ≥ z are 0. If the entry is null or s ≥ z, the contribution is zero.
- States:
  - IDLE:
    - Accumulators acc[0..MB_MAX-1] are 0.
    - in_ready = params legal. Legal means frm_z_sel≠3, 1≤frm_kb≤KB_MAX, 1≤frm_mb≤MB_MAX.
    - An accepted beat latches z, kb and mb, processes that beat as column 0, sets col=1, and goes to ACCUM. If kb=1, it goes directly to DRAIN.
    - If in_valid and params are illegal, frm_err pulses next cycle and no beat is consumed.
  - ACCUM:
    - in_ready=1.
    - Each accepted beat does acc[r] ^= rot(in_data, shift[r][col]) for all r<mb, then col++.
    - The beat with col=kb-1 moves the FSM to DRAIN.
    - frm_* inputs are not re-sampled.
  - DRAIN:
    - in_ready=0, par_valid=1.
    - par_data = acc[par_idx] and par_idx starts at 0. par_last = (par_idx==mb-1).
    - Each accepted beat increments par_idx. The last beat clears all accumulators and returns to IDLE.
- Parity definition: P[r] = XOR over c<kb of rot(I[c], shift[r][c]).
- Rows ≥ mb are never updated or output.

## Timing
- Reset values: in_ready=0 during reset; par_valid=0, par_data=0, par_idx=0, par_last=0, frm_err=0. State is IDLE and accumulators are 0.
- In the first cycle after reset deasserts, in_ready follows the legality of frm_*.
- Throughput: one info beat per cycle while in_valid=1; no bubbles inside a frame.
- Latency: par_valid rises the cycle after the kb-th info beat is accepted.
- Backpressure: while par_valid=1 and par_ready=0, par_data, par_idx and par_last hold stable.
- Turnaround: IDLE is entered the cycle after the final parity handshake. in_ready may be 1 in that cycle, so the gap is one cycle minimum from the last parity beat to the next first info beat.
- Writing cfg during ACCUM or DRAIN has no effect. A write and a first beat in the same IDLE cycle: the write lands, but beat 0 uses the old entry.
- Reset mid-frame (ACCUM or DRAIN): the next cycle is IDLE with accumulators and the table cleared, and no par beat is emitted.
- rot is combinational, one barrel rotator per row. acc updates are registered.

## Test plan
- Reset: hold rst 2 cycles with legal frm_* inputs. Required: every output is 0 during reset, in_ready=1 the cycle after release, and all table entries read back as null (frame yields parity 0).
- Basic, z=27, kb=2, mb=1:
  - Load shift[0][0]=0 and shift[0][1]=1.
  - Send info0=0x1, then info1=0x1.
  - Required: par_valid one cycle later, par_data=0x3, par_idx=0, par_last=1.
- Wrap, z=54, kb=1, mb=1:
  - Load shift[0][0]=53.
  - Send in_data with bit 1 and bit 60 set.
  - Required: par_data=0x1, since bit 60 is ignored and bit 53 of the output is 0.
- Null and out-of-range shift, z=27, kb=2, mb=1:
  - Load entry (0,0) with cfg_null=1 and entry (0,1) with shift=27.
  - Send info blocks of all ones.
  - Required: par_data=0.
- Backpressure, z=81, kb=3, mb=3:
  - Hold par_ready=0 for 3 cycles on each beat.
  - Required: each beat is stable while stalled, par_idx steps 0,1,2, par_last only on idx 2, and IDLE is reached the cycle after the third handshake.
- Errors and abort:
  - frm_z_sel=3 with in_valid=1: in_ready=0, frm_err pulses once per attempted cycle.
  - Assert rst after 5 of 20 beats: no par beat follows. The next legal frame matches the golden model with a freshly loaded table.

Source files
------------

// File: rtl/qc_ldpc_enc_stream.sv
// Block-serial QC-LDPC parity encoder: info blocks are rotated by a runtime shift table,
// XOR-accumulated into every parity row in parallel, then streamed out one row per beat.
module qc_ldpc_enc_stream #(
    parameter int ZMAX   = 81,
    parameter int KB_MAX = 20,
    parameter int MB_MAX = 12,
    parameter int SW     = $clog2(ZMAX)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [$clog2(MB_MAX)-1:0] cfg_row,
    input  logic [$clog2(KB_MAX)-1:0] cfg_col,
    input  logic [SW-1:0]             cfg_shift,
    input  logic                      cfg_null,
    input  logic [1:0]                frm_z_sel,
    input  logic [4:0]                frm_kb,
    input  logic [3:0]                frm_mb,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ZMAX-1:0]           in_data,
    output logic                      par_valid,
    input  logic                      par_ready,
    output logic [ZMAX-1:0]           par_data,
    output logic [$clog2(MB_MAX)-1:0] par_idx,
    output logic                      par_last,
    output logic                      frm_err
);

    localparam int RW = $clog2(MB_MAX);
    localparam int CW = $clog2(KB_MAX);
    localparam int ZW = $clog2(ZMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [ZW-1:0]   z_q;
    logic [4:0]      kb_q;
    logic [3:0]      mb_q;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   idx_q;

    logic            tbl_null  [MB_MAX][KB_MAX];
    logic [SW-1:0]   tbl_shift [MB_MAX][KB_MAX];
    logic [ZMAX-1:0] acc       [MB_MAX];
    logic [ZMAX-1:0] contrib   [MB_MAX];

    logic            legal;
    logic            accept;
    logic            par_fire;
    logic [ZW-1:0]   eff_z;
    logic [3:0]      eff_mb;
    logic [CW-1:0]   cur_col;

    function automatic logic [ZW-1:0] z_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return ZW'(27);
            2'd1:    return ZW'(54);
            default: return ZW'(81);
        endcase
    endfunction

    function automatic logic [ZMAX-1:0] zmask(input logic [ZW-1:0] z);
        return (ZMAX'(1) << z) - ZMAX'(1);
    endfunction

    // Cyclic rotation within the low z bits; caller guarantees s < z.
    function automatic logic [ZMAX-1:0] rot(input logic [ZMAX-1:0] v,
                                            input logic [SW-1:0]   s,
                                            input logic [ZW-1:0]   z);
        logic [ZMAX-1:0] vm;
        vm = v & zmask(z);
        return ((vm << s) | (vm >> (z - ZW'(s)))) & zmask(z);
    endfunction

    assign legal = (frm_z_sel != 2'd3) &&
                   (frm_kb != 5'd0) && (frm_kb <= 5'(KB_MAX)) &&
                   (frm_mb != 4'd0) && (frm_mb <= 4'(MB_MAX));

    assign in_ready  = !rst && (((state == S_IDLE) && legal) || (state == S_ACCUM));
    assign accept    = in_valid && in_ready;
    assign par_valid = !rst && (state == S_DRAIN);
    assign par_fire  = par_valid && par_ready;
    assign par_idx   = par_valid ? idx_q : '0;
    assign par_data  = par_valid ? acc[idx_q] : '0;
    assign par_last  = par_valid && (idx_q == RW'(mb_q - 4'd1));

    // The first beat of a frame is processed with the live frm_* fields.
    assign eff_z   = (state == S_IDLE) ? z_of(frm_z_sel) : z_q;
    assign eff_mb  = (state == S_IDLE) ? frm_mb : mb_q;
    assign cur_col = (state == S_IDLE) ? '0 : col_q;

    always_comb begin
        for (int r = 0; r < MB_MAX; r++) begin
            contrib[r] = '0;
            if ((r < int'(eff_mb)) && !tbl_null[r][cur_col] &&
                (ZW'(tbl_shift[r][cur_col]) < eff_z))
                contrib[r] = rot(in_data, tbl_shift[r][cur_col], eff_z);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            z_q     <= '0;
            kb_q    <= '0;
            mb_q    <= '0;
            col_q   <= '0;
            idx_q   <= '0;
            frm_err <= 1'b0;
            for (int r = 0; r < MB_MAX; r++) begin
                acc[r] <= '0;
                for (int c = 0; c < KB_MAX; c++) begin
                    tbl_null[r][c]  <= 1'b1;
                    tbl_shift[r][c] <= '0;
                end
            end
        end else begin
            frm_err <= (state == S_IDLE) && in_valid && !legal;
            case (state)
                S_IDLE: begin
                    if (cfg_we && (int'(cfg_row) < MB_MAX) && (int'(cfg_col) < KB_MAX)) begin
                        tbl_null[cfg_row][cfg_col]  <= cfg_null;
                        tbl_shift[cfg_row][cfg_col] <= cfg_shift;
                    end
                    if (accept) begin
                        z_q   <= z_of(frm_z_sel);
                        kb_q  <= frm_kb;
                        mb_q  <= frm_mb;
                        col_q <= CW'(1);
                        idx_q <= '0;
                        for (int r = 0; r < MB_MAX; r++)
                            acc[r] <= contrib[r];
                        state <= (frm_kb == 5'd1) ? S_DRAIN : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        for (int r = 0; r < MB_MAX; r++)
                            acc[r] <= acc[r] ^ contrib[r];
                        col_q <= col_q + CW'(1);
                        if (col_q == CW'(kb_q - 5'd1))
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (par_fire) begin
                        if (par_last) begin
                            for (int r = 0; r < MB_MAX; r++)
                                acc[r] <= '0;
                            idx_q <= '0;
                            state <= S_IDLE;
                        end else begin
                            idx_q <= idx_q + RW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qc_ldpc_enc_stream.sv
// Scoreboard bench for qc_ldpc_enc_stream: a bit-level parity model fills an expectation
// queue per frame, and a negedge monitor checks every presented parity beat against it.
module tb_qc_ldpc_enc_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [3:0]  cfg_row;
    logic [4:0]  cfg_col;
    logic [6:0]  cfg_shift;
    logic        cfg_null;
    logic [1:0]  frm_z_sel;
    logic [4:0]  frm_kb;
    logic [3:0]  frm_mb;
    logic        in_valid;
    logic        in_ready;
    logic [80:0] in_data;
    logic        par_valid;
    logic        par_ready;
    logic [80:0] par_data;
    logic [3:0]  par_idx;
    logic        par_last;
    logic        frm_err;

    qc_ldpc_enc_stream dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_col(cfg_col),
        .cfg_shift(cfg_shift), .cfg_null(cfg_null),
        .frm_z_sel(frm_z_sel), .frm_kb(frm_kb), .frm_mb(frm_mb),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .par_valid(par_valid), .par_ready(par_ready), .par_data(par_data),
        .par_idx(par_idx), .par_last(par_last), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [80:0] d;
        int          idx;
        logic        last;
    } exp_t;

    exp_t        expq [$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    bit          m_null  [12][20];
    int          m_shift [12][20];
    logic [80:0] fix_blk [20];
    bit          auto_ready = 1'b1;
    bit          rnd_ready  = 1'b0;

    task automatic check(input string nm, input logic [80:0] act, input logic [80:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_clear();
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 20; c++) begin
                m_null[r][c]  = 1'b1;
                m_shift[r][c] = 0;
            end
    endtask

    // Contribution of one info block to one parity row, bit by bit.
    function automatic logic [80:0] mdl_col(input int z, input int r, input int c, input logic [80:0] v);
        logic [80:0] p;
        int s;
        p = '0;
        if (m_null[r][c] || m_shift[r][c] >= z) return p;
        s = m_shift[r][c];
        for (int j = 0; j < z; j++)
            if (v[j]) p[(j + s) % z] = ~p[(j + s) % z];
        return p;
    endfunction

    task automatic cfg_write(input int r, input int c, input int s, input bit nl);
        cfg_we = 1'b1; cfg_row = 4'(r); cfg_col = 5'(c); cfg_shift = 7'(s); cfg_null = nl;
        step();
        cfg_we = 1'b0;
        m_null[r][c]  = nl;
        m_shift[r][c] = s;
    endtask

    task automatic load_random(input int kb, input int mb);
        for (int r = 0; r < mb; r++)
            for (int c = 0; c < kb; c++)
                cfg_write(r, c, int'($urandom_range(0, 90)), ($urandom % 4) == 0);
    endtask

    task automatic send_frame(input int zsel, input int kb, input int mb, input int nsend,
                              input bit gaps, input bit cwr, input bit fixd,
                              input bit chk0, input logic [80:0] exp0);
        int          z;
        int          n;
        bit          ok;
        logic [95:0] t96;
        logic [80:0] blk [20];
        logic [80:0] c0  [12];
        logic [80:0] p;
        exp_t        e;
        int          wr_r, wr_s;
        bit          wr_n;
        z = (zsel == 0) ? 27 : (zsel == 1) ? 54 : 81;
        for (int c = 0; c < kb; c++) begin
            t96 = {$urandom(), $urandom(), $urandom()};
            blk[c] = fixd ? fix_blk[c] : t96[80:0];
        end
        frm_z_sel = 2'(zsel); frm_kb = 5'(kb); frm_mb = 4'(mb);
        wr_r = int'($urandom_range(0, 11));
        wr_s = int'($urandom_range(0, 90));
        wr_n = ($urandom % 4) == 0;
        if (nsend == kb) begin
            for (int r = 0; r < mb; r++) c0[r] = mdl_col(z, r, 0, blk[0]);
            if (cwr) begin
                m_null[wr_r][0]  = wr_n;
                m_shift[wr_r][0] = wr_s;
            end
            for (int r = 0; r < mb; r++) begin
                p = c0[r];
                for (int c = 1; c < kb; c++) p = p ^ mdl_col(z, r, c, blk[c]);
                e.d = p; e.idx = r; e.last = (r == mb - 1);
                expq.push_back(e);
            end
        end else if (cwr) begin
            m_null[wr_r][0]  = wr_n;
            m_shift[wr_r][0] = wr_s;
        end
        for (int c = 0; c < nsend; c++) begin
            if (gaps && ($urandom % 3) == 0) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_data  = blk[c];
            if (cwr && c == 0) begin
                cfg_we = 1'b1; cfg_row = 4'(wr_r); cfg_col = 5'd0;
                cfg_shift = 7'(wr_s); cfg_null = wr_n;
            end else if (cwr && c == 1) begin
                // Not mirrored in the model: the table is frozen once a frame is running.
                cfg_we = 1'b1; cfg_row = 4'($urandom_range(0, 11)); cfg_col = 5'($urandom_range(0, 19));
                cfg_shift = 7'($urandom_range(0, 90)); cfg_null = $urandom % 2;
            end
            n = 0;
            do begin
                @(negedge clk);
                ok = in_ready;
                step();
                n++;
            end while (!ok && n < 50);
            cfg_we = 1'b0;
            if (!ok) check("in_ready_timeout", 81'(ok), 81'd1);
        end
        in_valid = 1'b0;
        if (nsend == kb) begin
            @(negedge clk);
            check("latency_par_valid", 81'(par_valid), 81'd1);
            if (chk0) check("first_par_data", par_data, exp0);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 1000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (expq.size() != 0) begin
            check("drain_timeout", 81'(expq.size()), 81'd0);
            expq.delete();
        end else begin
            check("turnaround_in_ready", 81'(in_ready), 81'd1);
            check("turnaround_par_valid", 81'(par_valid), 81'd0);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (auto_ready) par_ready = rnd_ready ? (($urandom % 3) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst && par_valid) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_par_beat: got idx=%0d data=%h want no beat", par_idx, par_data);
            end else begin
                mon_e = expq[0];
                check("par_data", par_data, mon_e.d);
                check("par_idx", 81'(par_idx), 81'(mon_e.idx));
                check("par_last", 81'(par_last), 81'(mon_e.last));
                if (par_ready) void'(expq.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_row = '0; cfg_col = '0; cfg_shift = '0; cfg_null = 1'b0;
        frm_z_sel = 2'd0; frm_kb = 5'd2; frm_mb = 4'd2;
        in_valid = 1'b0; in_data = '0; par_ready = 1'b1;
        mdl_clear();
        for (int c = 0; c < 20; c++) fix_blk[c] = '0;

        // Reset: all outputs low while held, in_ready follows legality after release.
        repeat (2) begin
            @(negedge clk);
            check("rst_in_ready", 81'(in_ready), 81'd0);
            check("rst_par_valid", 81'(par_valid), 81'd0);
            check("rst_par_data", par_data, 81'd0);
            check("rst_par_idx", 81'(par_idx), 81'd0);
            check("rst_par_last", 81'(par_last), 81'd0);
            check("rst_frm_err", 81'(frm_err), 81'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 81'(in_ready), 81'd1);
        step();
        send_frame(0, 2, 2, 2, 0, 0, 0, 1, 81'd0);
        wait_drain();

        // Basic z=27 kb=2 mb=1
        cfg_write(0, 0, 0, 0);
        cfg_write(0, 1, 1, 0);
        fix_blk[0] = 81'h1; fix_blk[1] = 81'h1;
        send_frame(0, 2, 1, 2, 0, 0, 1, 1, 81'h3);
        wait_drain();

        // Wrap z=54: bit 1 rotates to bit 0, bit 60 is outside the circulant
        cfg_write(0, 0, 53, 0);
        fix_blk[0] = (81'd1 << 1) | (81'd1 << 60);
        send_frame(1, 1, 1, 1, 0, 0, 1, 1, 81'h1);
        wait_drain();

        // Null entry and out-of-range shift contribute nothing
        cfg_write(0, 0, 0, 1);
        cfg_write(0, 1, 27, 0);
        fix_blk[0] = '1; fix_blk[1] = '1;
        send_frame(0, 2, 1, 2, 0, 0, 1, 1, 81'd0);
        wait_drain();

        // Backpressure z=81 kb=3 mb=3, three stall cycles per beat
        load_random(3, 3);
        auto_ready = 1'b0;
        par_ready  = 1'b0;
        send_frame(2, 3, 3, 3, 0, 0, 0, 0, 81'd0);
        for (int b = 0; b < 3; b++) begin
            par_ready = 1'b0;
            repeat (3) step();
            par_ready = 1'b1;
            step();
        end
        check("bp_idle_in_ready", 81'(in_ready), 81'd1);
        check("bp_idle_par_valid", 81'(par_valid), 81'd0);
        check("bp_queue_empty", 81'(expq.size()), 81'd0);
        auto_ready = 1'b1;

        // Illegal circulant select: no beat taken, one error pulse per attempted cycle
        frm_z_sel = 2'd3; frm_kb = 5'd2; frm_mb = 4'd1;
        in_valid = 1'b1;
        @(negedge clk);
        check("err_in_ready", 81'(in_ready), 81'd0);
        check("err_first", 81'(frm_err), 81'd0);
        repeat (2) begin
            step();
            @(negedge clk);
            check("err_in_ready", 81'(in_ready), 81'd0);
            check("err_pulse", 81'(frm_err), 81'd1);
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("err_pulse_last", 81'(frm_err), 81'd1);
        step();
        @(negedge clk);
        check("err_clear", 81'(frm_err), 81'd0);
        frm_z_sel = 2'd0; frm_kb = 5'd0;
        @(negedge clk);
        check("kb0_in_ready", 81'(in_ready), 81'd0);
        frm_kb = 5'd2;
        step();

        // Abort after 5 of 20 beats
        load_random(20, 12);
        send_frame(2, 20, 12, 5, 0, 0, 0, 0, 81'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        mdl_clear();
        repeat (20) begin
            @(negedge clk);
            check("abort_no_par", 81'(par_valid), 81'd0);
        end
        step();
        send_frame(1, 3, 2, 3, 0, 0, 0, 1, 81'd0);
        wait_drain();
        load_random(20, 12);
        send_frame(2, 20, 12, 20, 0, 0, 0, 0, 81'd0);
        wait_drain();

        // Randomized frames with gaps, random backpressure and cfg writes alongside beats
        rnd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int zs, kb, mb;
            zs = int'($urandom_range(0, 2));
            kb = int'($urandom_range(1, 20));
            mb = int'($urandom_range(1, 12));
            load_random(kb, mb);
            send_frame(zs, kb, mb, kb, 1, $urandom % 2, 0, 0, 81'd0);
            wait_drain();
        end
        rnd_ready = 1'b0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
